bus_txn_ctrl: RTL and testbench

- Downstream stage of the two-master bus arbiter.
- Consumes the registered grant1/grant2 pair, latches the winning master's address, write data and direction, and runs one single-beat valid/ready transaction on the shared slave bus.
- Returns a one-cycle done pulse to the owning master, plus read data on reads.
- Serialises all slave accesses so at most one transaction is outstanding.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_timeout_ctr.sv | 37 +++
 rtl/bus_txn_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bus_txn_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state/owner encodings and default widths for bus_txn_ctrl
package bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M1   = 2'd1,
        OWN_M2   = 2'd2
    } owner_e;

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - stall counter for the REQ phase, built only with BUS_TIMEOUT_EN
module bus_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One more stalled cycle brings the count to TIMEOUT: that cycle is the abort cycle.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_txn_ctrl.sv
// rtl/bus_txn_ctrl.sv - single-beat slave bus transaction controller behind the two-master arbiter (optional BUS_TIMEOUT_EN)
module bus_txn_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant1,
    input  logic              grant2,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic              m2_we,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              m1_done,
    output logic              m2_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              s_valid_q, s_valid_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              s_we_q, s_we_d;
    logic              m1_done_q, m1_done_d;
    logic              m2_done_q, m2_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              abort;

`ifdef BUS_TIMEOUT_EN
    logic tmo_expired;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_IDLE),
        .inc     ((state_q == ST_REQ) && !s_ready),
        .expired (tmo_expired)
    );

    assign abort = (state_q == ST_REQ) && !s_ready && tmo_expired;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT >= 1);
    assign abort          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        s_valid_d = 1'b0;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_we_d    = s_we_q;
        m1_done_d = 1'b0;
        m2_done_d = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Master 1 has priority when both grants arrive together.
                if (grant1) begin
                    owner_d   = OWN_M1;
                    s_addr_d  = m1_addr;
                    s_wdata_d = m1_wdata;
                    s_we_d    = m1_we;
                    s_valid_d = 1'b1;
                    state_d   = ST_REQ;
                end else if (grant2) begin
                    owner_d   = OWN_M2;
                    s_addr_d  = m2_addr;
                    s_wdata_d = m2_wdata;
                    s_we_d    = m2_we;
                    s_valid_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                s_valid_d = 1'b1;
                if (s_ready) begin
                    if (!s_we_q) begin
                        rdata_d = s_rdata;
                    end
                    s_valid_d = 1'b0;
                    m1_done_d = (owner_q == OWN_M1);
                    m2_done_d = (owner_q == OWN_M2);
                    state_d   = ST_DONE;
                end else if (abort) begin
                    s_valid_d = 1'b0;
                    m1_done_d = (owner_q == OWN_M1);
                    m2_done_d = (owner_q == OWN_M2);
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_we_q    <= 1'b0;
            m1_done_q <= 1'b0;
            m2_done_q <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_we_q    <= s_we_d;
            m1_done_q <= m1_done_d;
            m2_done_q <= m2_done_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign s_valid = s_valid_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_we    = s_we_q;
    assign m1_done = m1_done_q;
    assign m2_done = m2_done_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// tb/tb_bus_txn_ctrl.sv - scoreboard bench for bus_txn_ctrl (default and BUS_TIMEOUT_EN builds)
module tb_bus_txn_ctrl;

    localparam int TMO = 4;

    logic       clk;
    logic       rst_n;
    logic       grant1, grant2;
    logic [7:0] m1_addr, m1_wdata, m2_addr, m2_wdata;
    logic       m1_we, m2_we;
    logic       s_valid, s_we, s_ready;
    logic [7:0] s_addr, s_wdata, s_rdata;
    logic       m1_done, m2_done, busy, err;
    logic [7:0] rdata;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic [7:0] rdata;
        logic       err;
        int         vcyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl_rdata;
    int         n_checks;
    int         n_fails;
    int         vcnt;
    bit         mon_en;

    bus_txn_ctrl #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .grant1   (grant1),
        .grant2   (grant2),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m2_addr  (m2_addr),
        .m2_wdata (m2_wdata),
        .m2_we    (m2_we),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_we     (s_we),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .m1_done  (m1_done),
        .m2_done  (m2_done),
        .rdata    (rdata),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input logic [1:0] own, input int vcyc,
                                     input logic [7:0] rd, input logic is_err);
        exp_t e;
        e.owner = own;
        e.addr  = (own == 2'd1) ? m1_addr  : m2_addr;
        e.wdata = (own == 2'd1) ? m1_wdata : m2_wdata;
        e.we    = (own == 2'd1) ? m1_we    : m2_we;
        e.rdata = (e.we || is_err) ? mdl_rdata : rd;
        e.err   = is_err;
        e.vcyc  = vcyc;
        mdl_rdata = e.rdata;
        sb.push_back(e);
    endfunction

    // Handshake and completion monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            vcnt = 0;
        end else begin
            if (s_valid) begin
                vcnt++;
                if (sb.size() == 0) begin
                    check("valid_unexpected", s_valid, 1'b0);
                end else begin
                    check("s_addr", s_addr, sb[0].addr);
                    check("s_wdata", s_wdata, sb[0].wdata);
                    check("s_we", s_we, sb[0].we);
                end
            end
            if (m1_done || m2_done || err) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", {m1_done, m2_done, err}, 3'b000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("m1_done", m1_done, e.owner == 2'd1);
                    check("m2_done", m2_done, e.owner == 2'd2);
                    check("err", err, e.err);
                    check("rdata", rdata, e.rdata);
                    check("valid_cycles", vcnt, e.vcyc);
                    check("busy_in_done", busy, 1'b1);
                    check("valid_in_done", s_valid, 1'b0);
                end
                vcnt = 0;
            end
        end
    end

    task automatic txn(input logic g1, input logic g2, input int waits,
                       input logic [7:0] rd, input bit scramble);
        push_exp(g1 ? 2'd1 : 2'd2, waits + 1, rd, 1'b0);
        grant1  = g1;
        grant2  = g2;
        s_rdata = rd;
        s_ready = (waits == 0);
        tick();
        grant1 = 1'b0;
        grant2 = 1'b0;
        check("valid_after_grant", s_valid, 1'b1);
        if (scramble) begin
            m1_addr  = ~m1_addr;
            m1_wdata = ~m1_wdata;
            m1_we    = ~m1_we;
            m2_addr  = ~m2_addr;
            m2_wdata = ~m2_wdata;
            m2_we    = ~m2_we;
        end
        for (int i = 0; i < waits; i++) begin
            tick();
            if (i == waits - 1) s_ready = 1'b1;
        end
        tick();
        s_ready = 1'b0;
        check("done_seen", m1_done | m2_done, 1'b1);
        tick();
        check("busy_back_idle", busy, 1'b0);
        check("done_one_cycle", m1_done | m2_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        mdl_rdata = 8'h00;
        mon_en    = 1'b1;
        rst_n     = 1'b1;
        grant1 = 1'b0; grant2 = 1'b0; s_ready = 1'b0; s_rdata = 8'h00;
        m1_addr = 8'h00; m1_wdata = 8'h00; m1_we = 1'b0;
        m2_addr = 8'h00; m2_wdata = 8'h00; m2_we = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", {m1_done, m2_done}, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_s_addr", {s_addr, s_wdata, 7'd0, s_we}, 24'h0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read from master 1.
        m1_addr = 8'h3C; m1_wdata = 8'h11; m1_we = 1'b0;
        txn(1'b1, 1'b0, 0, 8'hA5, 1'b0);
        check("t1_rdata_held", rdata, 8'hA5);

        // Master 2 write with three wait states; read data must not move.
        m2_addr = 8'h77; m2_wdata = 8'h5A; m2_we = 1'b1;
        txn(1'b0, 1'b1, 3, 8'hEE, 1'b0);

        // Both grants: master 1 first, held grant2 served at the next IDLE.
        m1_addr = 8'h10; m1_we = 1'b0; m1_wdata = 8'h01;
        m2_addr = 8'h20; m2_we = 1'b1; m2_wdata = 8'h99;
        push_exp(2'd1, 1, 8'h6B, 1'b0);
        push_exp(2'd2, 1, 8'h00, 1'b0);
        grant1 = 1'b1; grant2 = 1'b1; s_ready = 1'b1; s_rdata = 8'h6B;
        tick();
        grant1 = 1'b0;
        check("both_m1_first", s_addr, 8'h10);
        tick();
        tick();
        check("both_idle_gap", busy, 1'b0);
        tick();
        grant2 = 1'b0;
        check("both_m2_next", s_addr, 8'h20);
        check("both_m2_valid", s_valid, 1'b1);
        tick();
        tick();
        s_ready = 1'b0;
        check("both_idle_end", busy, 1'b0);

        // Grant dropped and master inputs changed mid-transaction.
        m1_addr = 8'h42; m1_we = 1'b1; m1_wdata = 8'h33;
        txn(1'b1, 1'b0, 1, 8'h00, 1'b1);

        // Asynchronous reset in REQ.
        mon_en = 1'b0;
        m1_addr = 8'h55; m1_we = 1'b0;
        grant1 = 1'b1; s_ready = 1'b0;
        tick();
        grant1 = 1'b0;
        check("t5_valid_pre_rst", s_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", s_valid, 1'b0);
        check("t5_async_busy", busy, 1'b0);
        check("t5_async_done", {m1_done, m2_done}, 2'b00);
        check("t5_async_rdata", rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_idle_busy", busy, 1'b0);
        check("t5_idle_valid", s_valid, 1'b0);
        mdl_rdata = 8'h00;
        mon_en    = 1'b1;

`ifdef BUS_TIMEOUT_EN
        // Slave never answers: abort after TMO stalled cycles.
        m1_addr = 8'h2E; m1_we = 1'b0;
        push_exp(2'd1, TMO, 8'h00, 1'b1);
        grant1 = 1'b1; s_ready = 1'b0; s_rdata = 8'h77;
        tick();
        grant1 = 1'b0;
        repeat (TMO) tick();
        check("t6_abort_err", err, 1'b1);
        check("t6_abort_done", m1_done, 1'b1);
        tick();
        check("t6_idle_busy", busy, 1'b0);
        check("t6_err_pulse", err, 1'b0);
`else
        // Without the timeout the request waits as long as the slave stalls.
        m1_addr = 8'h2E; m1_we = 1'b0;
        push_exp(2'd1, 21, 8'h4D, 1'b0);
        grant1 = 1'b1; s_ready = 1'b0; s_rdata = 8'h4D;
        tick();
        grant1 = 1'b0;
        repeat (19) tick();
        check("t6_still_valid", s_valid, 1'b1);
        check("t6_no_err", err, 1'b0);
        check("t6_still_busy", busy, 1'b1);
        tick();
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        tick();
        check("t6_idle_busy", busy, 1'b0);
`endif

        // Ordinary traffic resumes afterwards.
        m2_addr = 8'h81; m2_we = 1'b0; m2_wdata = 8'h00;
        txn(1'b0, 1'b1, 2, 8'hC3, 1'b0);
        check("final_rdata", rdata, 8'hC3);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
